// File: rtl/present_inv_pkg.sv
// Shared definitions for the 3-share PRESENT inverse S-box layer.
//   nibble_t        4-bit share slice
//   NIBBLES         nibbles per layer invocation (16 for PRESENT)
//   state_e         layer FSM states
//   f_inv_share     one output share of F^-1 (direct sharing, first stage)
//   g_inv_share     one output share of G^-1 (direct sharing, second stage)
//   sbox_inv_ref    unshared S^-1 table, used by assertions only
// Optional feature macro: PRESENT_INV_SBOX_REFRESH_EN (see present_inv_sbox_ti_core).
package present_inv_pkg;

    typedef logic [3:0] nibble_t;

    localparam int unsigned NIBBLES = 16;

    typedef enum logic [1:0] {StIdle, StRun, StFlush} state_e;

    // Share of a product x*y built from the primary share p and one other share q.
    // Summed over the three cyclic (p, q) pairs this covers all nine cross products.
    function automatic logic and_share(input logic xp, input logic yp,
                                       input logic xq, input logic yq);
        return (xp & yp) ^ (xp & yq) ^ (xq & yp);
    endfunction

    // F^-1 with input bits {a,b,c,d} (a = MSB):
    //   y3 = b^c^cd^bc^ad^ac^ab   y2 = c^d^cd^bc^ad^ab
    //   y1 = c^d^bc^ac^ab         y0 = a^c
    function automatic nibble_t f_inv_share(input nibble_t p, input nibble_t q);
        logic ab, ac, ad, bc, cd;
        nibble_t y;
        ab = and_share(p[3], p[2], q[3], q[2]);
        ac = and_share(p[3], p[1], q[3], q[1]);
        ad = and_share(p[3], p[0], q[3], q[0]);
        bc = and_share(p[2], p[1], q[2], q[1]);
        cd = and_share(p[1], p[0], q[1], q[0]);
        y[3] = p[2] ^ p[1] ^ cd ^ bc ^ ad ^ ac ^ ab;
        y[2] = p[1] ^ p[0] ^ cd ^ bc ^ ad ^ ab;
        y[1] = p[1] ^ p[0] ^ bc ^ ac ^ ab;
        y[0] = p[3] ^ p[1];
        return y;
    endfunction

    // G^-1 with input bits {a,b,c,d} (a = MSB):
    //   y3 = a^d^bc               y2 = 1^c^d^bc^ab
    //   y1 = b^c^d^bc^ab          y0 = 1^a^b
    // The constant terms must be added in exactly one share (add_const).
    function automatic nibble_t g_inv_share(input nibble_t p, input nibble_t q,
                                            input logic add_const);
        logic ab, bc;
        nibble_t y;
        ab = and_share(p[3], p[2], q[3], q[2]);
        bc = and_share(p[2], p[1], q[2], q[1]);
        y[3] = p[3] ^ p[0] ^ bc;
        y[2] = p[1] ^ p[0] ^ bc ^ ab ^ add_const;
        y[1] = p[2] ^ p[1] ^ p[0] ^ bc ^ ab;
        y[0] = p[3] ^ p[2] ^ add_const;
        return y;
    endfunction

    function automatic nibble_t sbox_inv_ref(input nibble_t x);
        nibble_t y;
        unique case (x)
            4'h0: y = 4'h5;
            4'h1: y = 4'hE;
            4'h2: y = 4'hF;
            4'h3: y = 4'h8;
            4'h4: y = 4'hC;
            4'h5: y = 4'h1;
            4'h6: y = 4'h2;
            4'h7: y = 4'hD;
            4'h8: y = 4'hB;
            4'h9: y = 4'h4;
            4'hA: y = 4'h6;
            4'hB: y = 4'h3;
            4'hC: y = 4'h0;
            4'hD: y = 4'h7;
            4'hE: y = 4'h9;
            default: y = 4'hA;
        endcase
        return y;
    endfunction

endpackage

// File: rtl/present_inv_sbox_ti_core.sv
// Two-stage 3-share PRESENT inverse S-box (S^-1 = G^-1 o F^-1).
//   clk, rst                       clock, asynchronous active-high reset
//   share_in1..3                   input nibble shares (stage 1, F^-1)
//   rnd[7:0]                       refresh randomness, only with PRESENT_INV_SBOX_REFRESH_EN
//   share_out1..3                  output nibble shares (stage 2, G^-1 of the mid register)
// Output share j is computed from input shares j+1 and j+2 only, in both stages.
// With PRESENT_INV_SBOX_REFRESH_EN the mid register stores re-masked shares; the
// unshared value is unchanged because the three masks XOR to zero.
module present_inv_sbox_ti_core
    import present_inv_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  nibble_t    share_in1,
    input  nibble_t    share_in2,
    input  nibble_t    share_in3,
`ifdef PRESENT_INV_SBOX_REFRESH_EN
    input  logic [7:0] rnd,
`endif
    output nibble_t    share_out1,
    output nibble_t    share_out2,
    output nibble_t    share_out3
);

    nibble_t f1, f2, f3;
    nibble_t mid1_d, mid2_d, mid3_d;
    nibble_t mid1_q, mid2_q, mid3_q;

    always_comb begin
        f1 = f_inv_share(share_in2, share_in3);
        f2 = f_inv_share(share_in3, share_in1);
        f3 = f_inv_share(share_in1, share_in2);
    end

`ifdef PRESENT_INV_SBOX_REFRESH_EN
    always_comb begin
        mid1_d = f1 ^ rnd[3:0];
        mid2_d = f2 ^ rnd[7:4];
        mid3_d = f3 ^ rnd[3:0] ^ rnd[7:4];
    end
`else
    always_comb begin
        mid1_d = f1;
        mid2_d = f2;
        mid3_d = f3;
    end
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mid1_q <= '0;
            mid2_q <= '0;
            mid3_q <= '0;
        end else begin
            mid1_q <= mid1_d;
            mid2_q <= mid2_d;
            mid3_q <= mid3_d;
        end
    end

    always_comb begin
        share_out1 = g_inv_share(mid2_q, mid3_q, 1'b1);
        share_out2 = g_inv_share(mid3_q, mid1_q, 1'b0);
        share_out3 = g_inv_share(mid1_q, mid2_q, 1'b0);
    end

endmodule

// File: rtl/present_inv_sbox_layer_ti.sv
// Nibble-serial 3-share PRESENT inverse S-box layer, results written back in place.
//   clk, rst                       clock, asynchronous active-high reset
//   start                          request, only honoured while idle
//   state_in1..3                   64-bit input shares, captured on the accepting edge
//   rnd[7:0]                       refresh randomness, only with PRESENT_INV_SBOX_REFRESH_EN
//   busy                           high while a layer is in progress
//   done                           one-cycle pulse once all nibbles are written back
//   state_out1..3                  share registers (valid from done until the next start)
// Nibble cnt is issued to the core while nibble cnt-1 is written back, so a nibble is
// never read and written in the same cycle. Macro: PRESENT_INV_SBOX_REFRESH_EN.
module present_inv_sbox_layer_ti
    import present_inv_pkg::*;
#(
    parameter int unsigned NIBBLES = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [4*NIBBLES-1:0] state_in1,
    input  logic [4*NIBBLES-1:0] state_in2,
    input  logic [4*NIBBLES-1:0] state_in3,
`ifdef PRESENT_INV_SBOX_REFRESH_EN
    input  logic [7:0]           rnd,
`endif
    output logic                 busy,
    output logic                 done,
    output logic [4*NIBBLES-1:0] state_out1,
    output logic [4*NIBBLES-1:0] state_out2,
    output logic [4*NIBBLES-1:0] state_out3
);

    localparam int unsigned CntW = $clog2(NIBBLES);
    localparam logic [CntW-1:0] LastNib = CntW'(NIBBLES - 1);

    state_e                state_q, state_d;
    logic [CntW-1:0]       cnt_q, cnt_d;
    logic                  done_q, done_d;
    logic [4*NIBBLES-1:0]  sh1_q, sh1_d;
    logic [4*NIBBLES-1:0]  sh2_q, sh2_d;
    logic [4*NIBBLES-1:0]  sh3_q, sh3_d;

    nibble_t               iss1, iss2, iss3;
    nibble_t               wb1, wb2, wb3;
    logic                  wr_en;
    logic [CntW-1:0]       wr_idx;

    assign iss1 = sh1_q[{cnt_q, 2'b00} +: 4];
    assign iss2 = sh2_q[{cnt_q, 2'b00} +: 4];
    assign iss3 = sh3_q[{cnt_q, 2'b00} +: 4];

    present_inv_sbox_ti_core u_core (
        .clk        (clk),
        .rst        (rst),
        .share_in1  (iss1),
        .share_in2  (iss2),
        .share_in3  (iss3),
`ifdef PRESENT_INV_SBOX_REFRESH_EN
        .rnd        (rnd),
`endif
        .share_out1 (wb1),
        .share_out2 (wb2),
        .share_out3 (wb3)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        done_d  = 1'b0;
        sh1_d   = sh1_q;
        sh2_d   = sh2_q;
        sh3_d   = sh3_q;
        wr_en   = 1'b0;
        wr_idx  = cnt_q - 1'b1;

        unique case (state_q)
            StIdle: begin
                if (start) begin
                    sh1_d   = state_in1;
                    sh2_d   = state_in2;
                    sh3_d   = state_in3;
                    cnt_d   = '0;
                    state_d = StRun;
                end
            end
            StRun: begin
                // The core output is only meaningful once nibble 0 has passed stage 1.
                wr_en = (cnt_q != '0);
                if (cnt_q == LastNib) begin
                    state_d = StFlush;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            StFlush: begin
                wr_en   = 1'b1;
                wr_idx  = LastNib;
                done_d  = 1'b1;
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        if (wr_en) begin
            sh1_d[{wr_idx, 2'b00} +: 4] = wb1;
            sh2_d[{wr_idx, 2'b00} +: 4] = wb2;
            sh3_d[{wr_idx, 2'b00} +: 4] = wb3;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            done_q  <= 1'b0;
            sh1_q   <= '0;
            sh2_q   <= '0;
            sh3_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            done_q  <= done_d;
            sh1_q   <= sh1_d;
            sh2_q   <= sh2_d;
            sh3_q   <= sh3_d;
        end
    end

    assign busy       = (state_q != StIdle);
    assign done       = done_q;
    assign state_out1 = sh1_q;
    assign state_out2 = sh2_q;
    assign state_out3 = sh3_q;

    // Every written-back nibble must unmask to S^-1 of the nibble issued one edge earlier.
    nibble_t iss_x;
    assign iss_x = iss1 ^ iss2 ^ iss3;

    wb_matches_ref: assert property (@(posedge clk) disable iff (rst)
        wr_en |-> ((wb1 ^ wb2 ^ wb3) == sbox_inv_ref($past(iss_x))));

endmodule
